clkset_ctrl: RTL
================

Name: clkset_ctrl

Overview:
- Writer side of the 7-bit clock-config interface. Accepts CLKSET writes of the 8-bit CLK register from the hub/cog.
- Sequences them onto the `cfg` bus that feeds the clock generator.
- When a write newly enables the crystal oscillator or the PLL and selects it as source, the new enable bits are driven first. The old CLKSEL is held until a stabilisation delay expires, so the cog clock never switches onto an unstable source.
- Handles the CLK RESET bit by issuing a soft-reset pulse and returning the config to RCFAST.
- Runs on the fixed 160 MHz clock.

Parameters:
- OSC_WAIT, 1600000: stabilisation cycles after the oscillator is newly enabled (10 ms at 160 MHz).
- PLL_WAIT, 16000: stabilisation cycles after the PLL is newly enabled (100 us).
- RESET_CYCLES, 16: length of the soft_reset pulse in cycles; must be ≥ 1.
- CNT_W, 21: wait-counter width; must hold OSC_WAIT+PLL_WAIT.

Ports:
- clock  in  1  fixed 160 MHz clock (clock_160 domain); the only clock.
- res  in  1  reset, synchronous, active-high.
- set_req  in  1  CLKSET request; held high until set_ack is seen.
- set_data  in  8  CLK value. Bit [7]=RESET, [6]=PLLENA, [5]=OSCENA, [4:3]=OSCM, [2:0]=CLKSEL.
- set_ack  out  1  one-cycle pulse when a write is committed.
- cfg  out  7  config to the clock generator, {PLLENA,OSCENA,OSCM,CLKSEL}.
- busy  out  1  high while a sequence is in progress (WAIT or RST).
- soft_reset  out  1  chip soft-reset pulse.
- clk_reg  out  8  CLK readback: {1'b0, target value}.

Behaviour:
- Reset: one clock; res is synchronous and active-high.
  - Any cycle with res=1 forces state=IDLE, counter=0, cfg=0, clk_reg=0, set_ack=0, busy=0, soft_reset=0.
  - This applies mid-WAIT and mid-RST: no ack is issued and the pending write is dropped.
- States:
  - IDLE: accepts a request.
  - WAIT: counting down the stabilisation delay.
  - RST: holding soft_reset.
- Acceptance: a request is sampled only in IDLE with set_ack=0. A request held high through its ack cycle is therefore never accepted twice.
- Source classification:
  - uses_osc = CLKSEL in 010..111.
  - uses_pll = CLKSEL in 011..111.
- Wait length, computed on accept at cycle N, with cur = current cfg and new = set_data:
  - W = (new.OSCENA & ~cur.OSCENA & uses_osc(new) ? OSC_WAIT : 0) + (new.PLLENA & ~cur.PLLENA & uses_pll(new) ? PLL_WAIT : 0).
  - The sum is computed in CNT_W bits.
- Normal write (set_data[7]=0):
  - clk_reg = {1'b0, set_data[6:0]} at N+1.
  - W=0: cfg = set_data[6:0] and set_ack=1 at N+1; state stays IDLE.
  - W>0, at N+1: cfg = {new[6:3], cur[2:0]}, counter loaded with W-1, state=WAIT, busy=1.
  - In WAIT the counter decrements each cycle. When it is 0: cfg[2:0] = new CLKSEL, set_ack=1, busy=0, state=IDLE. This happens at cycle N+1+W.
  - Disabling bits, or selecting a source whose enable is 0, is applied directly with W=0; software is responsible.
- Reset write (set_data[7]=1):
  - Other bits are ignored.
  - At N+1: cfg=0, clk_reg=0, set_ack=1, soft_reset=1, busy=1, counter=RESET_CYCLES-1, state=RST.
  - soft_reset stays high through cycle N+RESET_CYCLES; then soft_reset=0, busy=0, state=IDLE.
- Requests during WAIT/RST: not accepted, no ack. The requester keeps set_req high and is served after return to IDLE.
- Outputs: all registered; set_ack is high for exactly one cycle per committed write.

Decomposition:
- Package clk_pkg holds:
  - bit-position constants PLLENA_B=6, OSCENA_B=5, OSCM_LSB=3, RESET_B=7;
  - CLKSEL enum: RCFAST=0, RCSLOW=1, XINPUT=2, PLL1X=3, PLL2X=4, PLL4X=5, PLL8X=6, PLL16X=7;
  - state enum {IDLE, WAIT, RST};
  - functions uses_osc() and uses_pll().
- One sub-module, clkset_wait_timer: loadable CNT_W down-counter with a zero flag and a synchronous clear. It is shared by WAIT and RST.

Test Plan (OSC_WAIT=100, PLL_WAIT=20, RESET_CYCLES=4):
- res held 3 cycles, then released -> cfg=0, clk_reg=0, set_ack=0, busy=0, soft_reset=0.
- From cfg=0, request 8'h01 at cycle 0 -> cfg=7'h01, clk_reg=8'h01, set_ack pulse at cycle 1, busy never high.
- From cfg=0, request 8'h6F -> cycle 1: cfg=7'h68, busy=1, clk_reg=8'h6F; cycle 121: cfg=7'h6F, set_ack=1, busy=0.
- From cfg=7'h6F, request 8'h6E -> no wait; cfg=7'h6E and ack at cycle 1.
- Request 8'h80 -> cycle 1: cfg=0 and set_ack=1; soft_reset high for cycles 1-4; busy falls at cycle 5.
- Reset mid-sequence: start the 8'h6F write, assert res at cycle 50 -> cfg=0, no ack. A following request of 8'h01 is acked 1 cycle after it is sampled.
- Hold set_req high for 5 cycles across an ack -> exactly one set_ack pulse.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared definitions for the CLKSET writer.
// Field positions, source select codes, sequencer states, source helpers.
package clk_pkg;

    localparam int RESET_B  = 7;
    localparam int PLLENA_B = 6;
    localparam int OSCENA_B = 5;
    localparam int OSCM_LSB = 3;

    typedef enum logic [2:0] {
        RCFAST = 3'd0,
        RCSLOW = 3'd1,
        XINPUT = 3'd2,
        PLL1X  = 3'd3,
        PLL2X  = 3'd4,
        PLL4X  = 3'd5,
        PLL8X  = 3'd6,
        PLL16X = 3'd7
    } clksel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RST  = 2'd2
    } state_e;

    // Crystal path feeds every source from XINPUT upward.
    function automatic logic uses_osc(input logic [2:0] sel);
        return sel >= XINPUT;
    endfunction

    // PLL feeds every source from PLL1X upward.
    function automatic logic uses_pll(input logic [2:0] sel);
        return sel >= PLL1X;
    endfunction

endpackage

// File: rtl/clkset_wait_timer.sv
// Loadable down-counter with zero flag and synchronous clear.
// Shared between the stabilisation wait and the soft-reset hold.
module clkset_wait_timer
    import clk_pkg::*;
#(
    parameter int CNT_W = 21
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clock) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/clkset_ctrl.sv
// CLKSET sequencer: commits CLK writes onto the clock-generator config,
// holding the old source until a newly enabled OSC/PLL has settled.
module clkset_ctrl
    import clk_pkg::*;
#(
    parameter int OSC_WAIT     = 1600000,
    parameter int PLL_WAIT     = 16000,
    parameter int RESET_CYCLES = 16,
    parameter int CNT_W        = 21
) (
    input  logic       clock,
    input  logic       res,
    input  logic       set_req,
    input  logic [7:0] set_data,
    output logic       set_ack,
    output logic [6:0] cfg,
    output logic       busy,
    output logic       soft_reset,
    output logic [7:0] clk_reg
);

    state_e     state_q, state_d;
    logic [6:0] cfg_q, cfg_d;
    logic [7:0] clk_reg_q, clk_reg_d;
    logic       ack_q, ack_d;
    logic       busy_q, busy_d;
    logic       sr_q, sr_d;
    logic [2:0] sel_q, sel_d;

    logic             t_load;
    logic [CNT_W-1:0] t_val;
    logic             t_dec;
    logic             t_zero;
    logic [CNT_W-1:0] wlen;
    logic             osc_new;
    logic             pll_new;

    clkset_wait_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .clr      (res),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    // Settling delay owed by the incoming write against the live config.
    always_comb begin
        osc_new = set_data[OSCENA_B] & ~cfg_q[OSCENA_B]
                & uses_osc(set_data[2:0]);
        pll_new = set_data[PLLENA_B] & ~cfg_q[PLLENA_B]
                & uses_pll(set_data[2:0]);
        wlen = (osc_new ? CNT_W'(OSC_WAIT) : '0)
             + (pll_new ? CNT_W'(PLL_WAIT) : '0);
    end

    // Sequencer next-state and registered-output values.
    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        clk_reg_d = clk_reg_q;
        ack_d     = 1'b0;
        busy_d    = busy_q;
        sr_d      = sr_q;
        sel_d     = sel_q;
        t_load    = 1'b0;
        t_val     = '0;
        t_dec     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (set_req && !ack_q) begin
                    if (set_data[RESET_B]) begin
                        cfg_d     = {4'b0000, RCFAST};
                        clk_reg_d = '0;
                        ack_d     = 1'b1;
                        sr_d      = 1'b1;
                        busy_d    = 1'b1;
                        t_load    = 1'b1;
                        t_val     = CNT_W'(RESET_CYCLES - 1);
                        state_d   = RST;
                    end else begin
                        clk_reg_d = {1'b0, set_data[6:0]};
                        if (wlen == '0) begin
                            cfg_d = set_data[6:0];
                            ack_d = 1'b1;
                        end else begin
                            cfg_d   = {set_data[6:OSCM_LSB], cfg_q[2:0]};
                            sel_d   = set_data[2:0];
                            busy_d  = 1'b1;
                            t_load  = 1'b1;
                            t_val   = wlen - CNT_W'(1);
                            state_d = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (t_zero) begin
                    cfg_d[2:0] = sel_q;
                    ack_d      = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            RST: begin
                if (t_zero) begin
                    sr_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    t_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; res drops any sequence in flight.
    always_ff @(posedge clock) begin
        if (res) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            clk_reg_q <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            sr_q      <= 1'b0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            clk_reg_q <= clk_reg_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            sr_q      <= sr_d;
            sel_q     <= sel_d;
        end
    end

    assign set_ack    = ack_q;
    assign cfg        = cfg_q;
    assign busy       = busy_q;
    assign soft_reset = sr_q;
    assign clk_reg    = clk_reg_q;

endmodule
